// File: rtl/riscv_pkg.sv
// Shared widths and writeback result-select encoding for the integer pipeline.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W      = 64;

  // 2'b11 is reserved and falls back to the ALU result.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/reg_file_array.sv
// Integer register storage: one synchronous write port, two combinational read ports, x0 hardwired to zero.
module reg_file_array #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: picks the WB result, commits it to the register file, bypasses it to decode reads,
// and counts retired instructions.
module writeback_regfile #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int CNT_W    = riscv_pkg::CNT_W,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic             register_write_wb,
  input  logic [1:0]       result_src_wb,
  input  logic [XLEN-1:0]  alu_result_wb,
  input  logic [XLEN-1:0]  read_data_wb,
  input  logic [XLEN-1:0]  pc_p_4_wb,
  input  logic [AW-1:0]    rd_wb,
  input  logic [AW-1:0]    rs1_addr_d,
  input  logic [AW-1:0]    rs2_addr_d,
  output logic [XLEN-1:0]  rs1_data_d,
  output logic [XLEN-1:0]  rs2_data_d,
  output logic [XLEN-1:0]  result_wb,
  output logic [CNT_W-1:0] instret
);

  import riscv_pkg::*;

  logic            w_wr;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_arr1;
  logic [XLEN-1:0] w_arr2;
  logic [CNT_W-1:0] r_instret;

  always_comb begin
    w_result = alu_result_wb;
    case (result_src_e'(result_src_wb))
      RES_MEM: w_result = read_data_wb;
      RES_PC4: w_result = pc_p_4_wb;
      default: ;
    endcase
  end

  // Reset gates the write, which also turns the bypass off for that cycle.
  assign w_wr = wb_valid && register_write_wb && (rd_wb != '0) && !reset;

  reg_file_array #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
    .clk      (clk),
    .i_rst    (reset),
    .i_we     (w_wr),
    .i_waddr  (rd_wb),
    .i_wdata  (w_result),
    .i_raddr1 (rs1_addr_d),
    .i_raddr2 (rs2_addr_d),
    .o_rdata1 (w_arr1),
    .o_rdata2 (w_arr2)
  );

  always_ff @(posedge clk) begin
    if (reset)         r_instret <= '0;
    else if (wb_valid) r_instret <= r_instret + 1'b1;
  end

  assign rs1_data_d = (w_wr && (rs1_addr_d == rd_wb)) ? w_result : w_arr1;
  assign rs2_data_d = (w_wr && (rs2_addr_d == rd_wb)) ? w_result : w_arr2;
  assign result_wb  = w_result;
  assign instret    = r_instret;

endmodule
